instruction_fetch: RTL

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_if.sv | 41 ++++
 rtl/instruction_fetch.sv | 106 ++++++++++
 2 files changed

// File: rtl/instruction_fetch_if.sv
// Instruction-fetch bus: the PC/instruction pair to instruction memory, the
// pipeline control inputs and the IF/ID register outputs.
// The fetch unit is the master. The surrounding pipeline and memory are the slave.
interface instruction_fetch_if;
    logic [31:0] PC;
    logic [31:0] Instruction;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectTarget;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC4;
    logic        IF_Valid;
    logic        AddrError;
    logic [31:0] InstCount;

    modport master (
        output PC,
        output IF_Instruction,
        output IF_PC4,
        output IF_Valid,
        output AddrError,
        output InstCount,
        input  Instruction,
        input  Stall,
        input  Redirect,
        input  RedirectTarget
    );

    modport slave (
        input  PC,
        input  IF_Instruction,
        input  IF_PC4,
        input  IF_Valid,
        input  AddrError,
        input  InstCount,
        output Instruction,
        output Stall,
        output Redirect,
        output RedirectTarget
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage with IF/ID pipeline register.
// PC is presented to a combinational instruction memory. The returned word is
// captured into IF/ID on the next rising edge.
// Redirect has priority over Stall, and Stall has priority over a sequential fetch.
// A misaligned redirect halts the block with a sticky AddrError.
// A fetch outside [0, 4*IMEM_WORDS) also halts it with a sticky AddrError.
// Only reset leaves the halted state.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic                clk,
    input  logic                reset,
    instruction_fetch_if.master bus
);

    // Exclusive upper bound of the fetch window. It is one bit wider than the
    // PC, so a window covering the full 4 GiB space cannot overflow.
    localparam logic [32:0] WINDOW_END = 33'(IMEM_WORDS) << 2;

    // Reset PC with the low bits cleared, so the PC is always word-aligned.
    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] if_instr_q;
    logic [31:0] if_pc4_q;
    logic        if_valid_q;
    logic        addr_err_q;
    logic [31:0] inst_count_q;

    logic [31:0] pc_plus4_d;
    logic [31:0] inst_count_inc_d;
    logic        in_window_d;
    logic        target_aligned_d;

    // Per-cycle decode: next sequential PC, window check and redirect alignment.
    always_comb begin
        pc_plus4_d       = pc_q + 32'd4;
        inst_count_inc_d = inst_count_q + 32'd1;
        in_window_d      = ({1'b0, pc_q} < WINDOW_END);
        target_aligned_d = (bus.RedirectTarget[1:0] == 2'b00);
    end

    // Fetch state machine and IF/ID register. All outputs are registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC_ALIGNED;
            if_instr_q   <= 32'h0;
            if_pc4_q     <= 32'h0;
            if_valid_q   <= 1'b0;
            addr_err_q   <= 1'b0;
            inst_count_q <= 32'h0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (bus.Redirect) begin
                        // A taken control transfer flushes the slot, even under Stall.
                        if_valid_q <= 1'b0;
                        if (target_aligned_d) begin
                            pc_q <= bus.RedirectTarget;
                        end else begin
                            addr_err_q <= 1'b1;
                            state_q    <= ST_HALT;
                        end
                    end else if (bus.Stall) begin
                        // Downstream is busy. Everything holds.
                        state_q <= ST_RUN;
                    end else if (in_window_d) begin
                        if_instr_q   <= bus.Instruction;
                        if_pc4_q     <= pc_plus4_d;
                        if_valid_q   <= 1'b1;
                        pc_q         <= pc_plus4_d;
                        inst_count_q <= inst_count_inc_d;
                    end else begin
                        // The PC ran off the end of instruction memory.
                        if_valid_q <= 1'b0;
                        addr_err_q <= 1'b1;
                        state_q    <= ST_HALT;
                    end
                end
                ST_HALT: begin
                    // Frozen until reset. IF_Valid is already 0.
                    if_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= ST_HALT;
                end
            endcase
        end
    end

    assign bus.PC             = pc_q;
    assign bus.IF_Instruction = if_instr_q;
    assign bus.IF_PC4         = if_pc4_q;
    assign bus.IF_Valid       = if_valid_q;
    assign bus.AddrError      = addr_err_q;
    assign bus.InstCount      = inst_count_q;

endmodule
